// File: rtl/mul_pkg.sv
// ============================================================================
// Module : mul_pkg
// Brief  : Shared widths, FSM state type and counter-width helper for the
//          sequential shift-add multiplier.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  // Width of a counter that can index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MUL_X_WIDTH   = 3;
  localparam int MUL_Y_WIDTH   = 3;
  localparam int MUL_P_WIDTH   = MUL_X_WIDTH + MUL_Y_WIDTH;
  localparam int MUL_CNT_WIDTH = cnt_width(MUL_Y_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_shift_add_step.sv
// ============================================================================
// Module : mul_shift_add_step
// Brief  : One combinational multiply step: acc + (a << shamt) when b_bit set.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_shift_add_step #(
  parameter int X_WIDTH = 3,
  parameter int P_WIDTH = 6,
  parameter int CNT_W   = 2
) (
  input  logic [P_WIDTH-1:0] acc,
  input  logic [X_WIDTH-1:0] a,
  input  logic               b_bit,
  input  logic [CNT_W-1:0]   shamt,
  output logic [P_WIDTH-1:0] sum
);

  logic [P_WIDTH-1:0] w_addend;

  assign w_addend = b_bit ? (P_WIDTH'(a) << shamt) : '0;
  assign sum      = acc + w_addend;

endmodule

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
// Module : mul_seq_ctrl
// Brief  : Sequential shift-add multiplier, one multiplier bit per cycle,
//          optional two's-complement operands with sign-magnitude result.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int X_WIDTH = MUL_X_WIDTH,
  parameter int Y_WIDTH = MUL_Y_WIDTH,
  parameter int P_WIDTH = X_WIDTH + Y_WIDTH,
  parameter bit SIGNED  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  output logic [P_WIDTH-1:0] p,
  output logic               s,
  output logic               rdy,
  output logic               busy
);

  localparam int               CNT_W  = cnt_width(Y_WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(Y_WIDTH - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [X_WIDTH-1:0] r_a;
  logic [Y_WIDTH-1:0] r_b;
  logic [P_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic [P_WIDTH-1:0] r_p;
  logic               r_s;

  logic [X_WIDTH-1:0] w_x_mag;
  logic [Y_WIDTH-1:0] w_y_mag;
  logic               w_sign;
  logic               w_accept;
  logic               w_last;
  logic               w_b_bit;
  logic [P_WIDTH-1:0] w_sum;

  // Magnitudes are taken once at acceptance so the iteration is always unsigned.
  generate
    if (SIGNED) begin : g_signed
      assign w_x_mag = x[X_WIDTH-1] ? (~x + X_WIDTH'(1)) : x;
      assign w_y_mag = y[Y_WIDTH-1] ? (~y + Y_WIDTH'(1)) : y;
      assign w_sign  = x[X_WIDTH-1] ^ y[Y_WIDTH-1];
    end else begin : g_unsigned
      assign w_x_mag = x;
      assign w_y_mag = y;
      assign w_sign  = 1'b0;
    end
  endgenerate

  assign w_accept = start && (r_state != ITER);
  assign w_last   = (r_cnt == C_LAST);
  assign w_b_bit  = r_b[r_cnt];

  mul_shift_add_step #(
    .X_WIDTH (X_WIDTH),
    .P_WIDTH (P_WIDTH),
    .CNT_W   (CNT_W)
  ) u_step (
    .acc   (r_acc),
    .a     (r_a),
    .b_bit (w_b_bit),
    .shamt (r_cnt),
    .sum   (w_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = ITER;
      ITER:    if (w_last) w_next_state = DONE;
      DONE:    w_next_state = start ? ITER : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_p    <= '0;
      r_s    <= 1'b0;
    end else if (w_accept) begin
      r_a    <= w_x_mag;
      r_b    <= w_y_mag;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sign <= w_sign;
    end else if (r_state == ITER) begin
      r_acc <= w_sum;
      if (w_last) begin
        r_cnt <= '0;
        r_p   <= w_sum;
        // A zero product has no sign in sign-magnitude form.
        r_s   <= r_sign && (w_sum != '0);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign p    = r_p;
  assign s    = r_s;
  assign busy = (r_state == ITER);
  assign rdy  = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
// ============================================================================
// Module : tb_mul_seq_ctrl
// Brief  : Scoreboard bench for mul_seq_ctrl, unsigned and signed instances.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq_ctrl;

  typedef struct {
    logic [5:0] p;
    logic       s;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_u = 1'b0;
  logic       start_s = 1'b0;
  logic [2:0] x_u = '0, y_u = '0, x_s = '0, y_s = '0;
  logic [5:0] p_u, p_s;
  logic       s_u, s_s, rdy_u, rdy_s, busy_u, busy_s;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q_u[$];
  exp_t q_s[$];

  mul_seq_ctrl #(.X_WIDTH(3), .Y_WIDTH(3), .P_WIDTH(6), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start_u), .x(x_u), .y(y_u),
    .p(p_u), .s(s_u), .rdy(rdy_u), .busy(busy_u)
  );

  mul_seq_ctrl #(.X_WIDTH(3), .Y_WIDTH(3), .P_WIDTH(6), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start_s), .x(x_s), .y(y_s),
    .p(p_s), .s(s_s), .rdy(rdy_s), .busy(busy_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Integer reference: plain multiply, then split into sign and magnitude.
  function automatic exp_t model(input bit sgn, input logic [2:0] xv, input logic [2:0] yv,
                                 input int c);
    int   xi, yi, pr;
    exp_t e;
    if (sgn) begin
      xi = int'($signed(xv));
      yi = int'($signed(yv));
    end else begin
      xi = int'(xv);
      yi = int'(yv);
    end
    pr    = xi * yi;
    e.s   = (pr < 0);
    if (pr < 0) pr = -pr;
    e.p   = 6'(pr);
    e.cyc = c;
    return e;
  endfunction

  task automatic drive(input bit sgn, input logic st, input logic [2:0] xv, input logic [2:0] yv);
    if (sgn) begin
      start_s = st; x_s = xv; y_s = yv;
    end else begin
      start_u = st; x_u = xv; y_u = yv;
    end
  endtask

  task automatic push(input bit sgn, input exp_t e);
    if (sgn) q_s.push_back(e);
    else     q_u.push_back(e);
  endtask

  task automatic drain(input bit sgn);
    for (int i = 0; i < 20 && (sgn ? q_s.size() : q_u.size()) != 0; i++) @(negedge clk);
    check(sgn ? "s_drain" : "u_drain", sgn ? q_s.size() : q_u.size(), 0);
  endtask

  // One start pulse; operands are replaced by xn/yn right after acceptance.
  task automatic run_op(input bit sgn, input logic [2:0] xv, input logic [2:0] yv,
                        input logic [2:0] xn, input logic [2:0] yn);
    int n0;
    @(negedge clk);
    drive(sgn, 1'b1, xv, yv);
    @(negedge clk);
    n0 = cyc;
    push(sgn, model(sgn, xv, yv, n0 + 3));
    drive(sgn, 1'b0, xn, yn);
    for (int i = 0; i < 3; i++) begin
      check(sgn ? "s_busy" : "u_busy", 32'(sgn ? busy_s : busy_u), 1);
      @(negedge clk);
    end
    check(sgn ? "s_busy_end" : "u_busy_end", 32'(sgn ? busy_s : busy_u), 0);
    drain(sgn);
  endtask

  always @(negedge clk) begin
    if (rdy_u) begin
      check("u_rdy_pending", 32'(q_u.size() > 0), 1);
      if (q_u.size() > 0) begin
        exp_t e;
        e = q_u.pop_front();
        check("u_p", 32'(p_u), 32'(e.p));
        check("u_s", 32'(s_u), 32'(e.s));
        check("u_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rdy_s) begin
      check("s_rdy_pending", 32'(q_s.size() > 0), 1);
      if (q_s.size() > 0) begin
        exp_t e;
        e = q_s.pop_front();
        check("s_p", 32'(p_s), 32'(e.p));
        check("s_s", 32'(s_s), 32'(e.s));
        check("s_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    repeat (2) @(negedge clk);
    check("rst_p_u", 32'(p_u), 0);
    check("rst_s_u", 32'(s_u), 0);
    check("rst_rdy_u", 32'(rdy_u), 0);
    check("rst_busy_u", 32'(busy_u), 0);
    check("rst_p_s", 32'(p_s), 0);
    check("rst_busy_s", 32'(busy_s), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_op(0, 3'd7, 3'd7, 3'd0, 3'd0);
    repeat (3) @(negedge clk);
    check("u_p_hold", 32'(p_u), 49);

    run_op(1, 3'b100, 3'b011, 3'd1, 3'd1);
    run_op(1, 3'b111, 3'b111, 3'd2, 3'd5);
    run_op(1, 3'b000, 3'b101, 3'd7, 3'd7);
    run_op(1, 3'b100, 3'b100, 3'd0, 3'd0);
    run_op(1, 3'b011, 3'b111, 3'd4, 3'd4);
    run_op(0, 3'd5, 3'd3, 3'd1, 3'd1);

    // Start held high: back-to-back accept from DONE, ignored inside ITER.
    @(negedge clk);
    drive(0, 1'b1, 3'd2, 3'd3);
    @(negedge clk);
    n0 = cyc;
    push(0, model(0, 3'd2, 3'd3, n0 + 3));
    push(0, model(0, 3'd5, 3'd5, n0 + 7));
    drive(0, 1'b1, 3'd5, 3'd5);
    repeat (4) @(negedge clk);
    check("u_b2b_busy", 32'(busy_u), 1);
    drive(0, 1'b0, 3'd1, 3'd1);
    drain(0);
    repeat (4) @(negedge clk);

    // Reset in the middle of an operation.
    @(negedge clk);
    drive(0, 1'b1, 3'd7, 3'd7);
    @(negedge clk);
    drive(0, 1'b0, 3'd7, 3'd7);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("u_abort_p", 32'(p_u), 0);
    check("u_abort_busy", 32'(busy_u), 0);
    check("u_abort_rdy", 32'(rdy_u), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    run_op(0, 3'd3, 3'd2, 3'd6, 3'd6);

    for (int i = 0; i < 6; i++) begin
      run_op(0, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      run_op(1, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
    end
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter X_WIDTH, default 3, multiplicand width.
REQ-002 Parameter Y_WIDTH, default 3, multiplier width; also the iteration count.
REQ-003 Parameter P_WIDTH, default X_WIDTH+Y_WIDTH, product width.
REQ-004 Parameter SIGNED, default 0; 1 selects two's-complement operands with a sign-magnitude result.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  request a multiply using the current x and y.
REQ-008 x  input  X_WIDTH  multiplicand operand.
REQ-009 y  input  Y_WIDTH  multiplier operand.
REQ-010 p  output  P_WIDTH  product magnitude, registered.
REQ-011 s  output  1  product sign (0 when SIGNED=0), registered.
REQ-012 rdy  output  1  one-cycle pulse: p and s are valid for a newly completed operation.
REQ-013 busy  output  1  high while an operation is in progress; start is ignored.

Function
REQ-014 States SHALL be IDLE, ITER and DONE, encoded as a 2-bit enum.
REQ-015 Start acceptance: an edge with start=1 in IDLE or DONE SHALL latch the operands into A and B, clear ACC, set count=0 and enter ITER; this is edge E0.
REQ-016 SIGNED=1: A and B SHALL hold operand magnitudes (-4 -> 4, 3 bits), and the sign register SHALL latch x[MSB]^y[MSB].
REQ-017 In ITER, each edge SHALL add A<<count to ACC when B[count]=1, then increment count; this uses one shared adder.
REQ-018 The edge on which count reaches Y_WIDTH-1 SHALL load p<=ACC result, s<=sign (forced to 0 if the result is 0), and enter DONE.
REQ-019 Latency: rdy SHALL be high in exactly the cycle after edge E(Y_WIDTH), with no data-dependent early exit.
REQ-020 DONE SHALL last one cycle; it goes to IDLE, or to ITER if start=1 (back-to-back, no bubble).
REQ-021 busy SHALL equal (state==ITER); rdy SHALL equal (state==DONE).
REQ-022 p and s SHALL hold their values through IDLE until the next completion, and SHALL not change during ITER.
REQ-023 start during ITER SHALL be ignored and not queued.
REQ-024 x and y changes after E0 SHALL not affect the result in flight.
REQ-025 The ACC width SHALL be P_WIDTH, with no overflow possible: the maximum magnitude product fits in P_WIDTH.

Reset
REQ-026 While rst=0, state SHALL be IDLE, p=0, s=0, rdy=0, busy=0, count=0, and A/B/ACC=0, asynchronously.
REQ-027 Reset asserted mid-ITER SHALL abort the operation; no rdy pulse follows release.
REQ-028 The first start accepted after rst releases SHALL behave as REQ-015.

Structure
REQ-029 The state enum, count width ($clog2(Y_WIDTH)) and default widths SHALL live in shared package mul_pkg, consistent with the global width defines.
REQ-030 The shift-add step (conditional add of shifted A into ACC) SHALL be one sub-module, mul_shift_add_step, which is purely combinational; the controller owns all registers.

Verification
REQ-031 Unsigned 3x3: x=7, y=7, start pulsed at E0 -> rdy high after E3 for one cycle, p=49, s=0, busy high for 3 cycles.
REQ-032 SIGNED=1: x=3'b100 (-4), y=3'b011 (3) -> p=12, s=1; then x=3'b111, y=3'b111 -> p=1, s=0.
REQ-033 SIGNED=1 zero sign: x=0, y=3'b101 (-3) -> p=0, s=0.
REQ-034 start held high continuously with x=2, y=3 then x=5, y=5 -> rdy pulses every 4th cycle (DONE->ITER), p=6 then p=25; start during ITER ignored.
REQ-035 Reset mid-op: x=7, y=7 accepted, rst=0 after E1 -> p=0, rdy never pulses; next op x=3, y=2 -> p=6.
REQ-036 Operand change: after E0 with x=5, y=3, switch to x=1, y=1 -> p=15.
